// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU, the result buffer and the result consumer.
// The buffer takes the slave view. The ALU/consumer side (or a bench) takes the master view.
interface alu_result_buffer_if;
  logic       in_valid;
  logic [3:0] in_result;
  logic       in_overflow;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_result;
  logic       out_overflow;
  logic       out_ready;

  modport master (
    output in_valid, in_result, in_overflow, out_ready,
    input  in_ready, out_valid, out_result, out_overflow
  );

  modport slave (
    input  in_valid, in_result, in_overflow, out_ready,
    output in_ready, out_valid, out_result, out_overflow
  );
endinterface

// File: rtl/alu_result_buffer.sv
// First-word-fall-through FIFO for ALU results, with valid/ready on both sides.
// Also keeps sticky/saturating overflow statistics over accepted entries.
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int OVF_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_result_buffer_if.slave       bus,
  input  logic                     clear_stats,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_sticky,
  output logic [OVF_W-1:0]         ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    FULL    = CW'(DEPTH);
  localparam logic [OVF_W-1:0] OVF_MAX = {OVF_W{1'b1}};

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [4:0]    head;
  logic          push;
  logic          pop;

  // in_ready depends only on registered occupancy, so a full buffer never accepts a push-through.
  assign bus.in_ready  = !rst && (count != FULL);
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign head             = mem[rd_ptr];
  assign bus.out_result   = bus.out_valid ? head[3:0] : 4'h0;
  assign bus.out_overflow = bus.out_valid ? head[4]   : 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_overflow, bus.in_result};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // An overflow push in the same cycle as clear_stats wins: the stats restart at one event.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (push && bus.in_overflow) begin
      ovf_sticky <= 1'b1;
      if (clear_stats) begin
        ovf_count <= OVF_W'(1);
      end else if (ovf_count != OVF_MAX) begin
        ovf_count <= ovf_count + OVF_W'(1);
      end
    end else if (clear_stats) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end
  end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Downstream stage of the 4-bit ALU. It captures each ALU result (`ALU_out`, `overflow`) presented with a valid strobe and queues it in a small first-word-fall-through FIFO for the consumer. It applies valid/ready backpressure on both sides. It also keeps overflow statistics: a sticky flag and a saturating counter. Together these decouple the combinational ALU from slower result sinks such as a register writeback or a scoreboard.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `OVF_W`, 8: width of the overflow event counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream has a result on `in_result`/`in_overflow`.
- `in_result`  in  4  ALU result (`ALU_out`).
- `in_overflow`  in  1  ALU overflow flag for this result.
- `in_ready`  out  1  buffer can accept an entry this cycle.
- `out_valid`  out  1  head entry is available.
- `out_result`  out  4  head entry result.
- `out_overflow`  out  1  head entry overflow flag.
- `out_ready`  in  1  consumer takes the head entry this cycle.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `clear_stats`  in  1  clears `ovf_sticky` and `ovf_count`.
- `ovf_sticky`  out  1  at least one accepted entry had overflow=1 since the last reset or clear.
- `ovf_count`  out  OVF_W  number of accepted overflow entries, saturating.

## Operation
- Push = `in_valid && in_ready`. Pop = `out_valid && out_ready`. Both are evaluated at the rising edge of `clk`.
- `in_ready` = `!rst && (count != DEPTH)`. It is a combinational function of registered state only and never depends on `out_ready`. There is no push-through when full.
- `out_valid` = `(count != 0)`.
- `out_result`/`out_overflow` show storage at the read pointer when `out_valid` is 1. They are forced to 0 when empty.
- Storage: `DEPTH` × 5-bit array, holding {overflow, result}. Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- Count update per edge:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, and both pointers advance
  - neither: hold
- Push while empty with `out_ready`=1: the entry is stored, not bypassed. It is popped no earlier than the next edge.
- Stats on a push with `in_overflow`=1: `ovf_sticky` ← 1 and `ovf_count` ← `ovf_count`+1, saturating at 2^OVF_W−1. Pushes with overflow=0 do not touch the stats.
- `clear_stats` alone: `ovf_sticky` ← 0, `ovf_count` ← 0.
- `clear_stats` together with an overflow push: the set wins, giving `ovf_sticky` = 1 and `ovf_count` = 1.
- `clear_stats` does not affect FIFO contents or pointers.
- `in_result`/`in_overflow` are ignored when no push occurs.

## Timing
- Reset, with `rst` sampled high at an edge: pointers, `count`, `ovf_sticky` and `ovf_count` go to 0.
- Outputs during and after reset, until the first push: `out_valid` = 0, `out_result` = 0, `out_overflow` = 0, `count` = 0, `ovf_sticky` = 0, `ovf_count` = 0. `in_ready` is 0 while `rst` is high and 1 on the first cycle after release.
- Reset mid-operation: all queued entries are discarded at that edge. A push or pop presented in the same cycle is ignored.
- Latency: an entry pushed at edge N appears with `out_valid` = 1 in the cycle after edge N. Minimum residency is one cycle.
- Throughput: one push and one pop per cycle, sustained, while 0 < `count` < `DEPTH`.
- Full (`count` = `DEPTH`): `in_ready` = 0. A pop at edge N raises `in_ready` in the cycle after edge N.
- Empty: a pop request is ignored, `count` does not underflow, and pointers hold.
- Stats outputs update at the same edge as the accepting push. `ovf_count` holds at all-ones once saturated.

## Test plan
- Reset, then push results 0x3, 0xA, 0xF with overflow 0, 1, 0, `out_ready` = 0 -> `count` = 3. Then raise `out_ready` -> pops 0x3/0, 0xA/1, 0xF/0 in order, `ovf_sticky` = 1, `ovf_count` = 1.
- Fill: 5 pushes with `DEPTH` = 4 and `out_ready` = 0 -> 4 accepted, `in_ready` = 0 after the 4th, and the 5th is held upstream. After one pop, the 5th is accepted on the next edge and order is preserved.
- Streaming with `in_valid` = `out_ready` = 1 for 20 cycles, driving 20 `$urandom` ALU results -> `count` stays at 1 after the first edge, and all 20 values emerge in order, crossing the pointer wrap.
- Empty pop: `out_ready` = 1 with no push for 3 cycles -> `out_valid` = 0, `count` = 0, outputs 0.
- Stats: push 300 entries with overflow = 1 and `OVF_W` = 8 -> `ovf_count` = 255. Then `clear_stats` in the same cycle as an overflow push -> `ovf_count` = 1, `ovf_sticky` = 1. Then `clear_stats` alone -> both 0.
- Assert `rst` for one cycle with `count` = 3 and a push presented -> next cycle `count` = 0, `out_valid` = 0, `ovf_count` = 0.
